instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Inverse of the control-path decoder: accepts per-instruction field descriptors and assembles RV32I 32-bit instruction words.
- Buffers the assembled words in a small FIFO and writes them sequentially into instruction memory through a write port with ready back-pressure.
- Used as the boot/program loader and as the bench-side stimulus source for the pipeline.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 10, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_last  in  1  marks the final descriptor of a session.
- in_fmt  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=LUI, 7=reserved.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_imm  in  32  sign-carrying immediate, byte offset for BRANCH/JAL.
- imem_we  out  1  write request.
- imem_ready  in  1  memory accepts a write when imem_we && imem_ready.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  instruction word.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  one-cycle pulse at session end.
- err  out  2  sticky: [0] illegal fmt, [1] address wrap or immediate range (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge), applies mid-session too:
  - state=IDLE; FIFO flushed.
  - imem_addr=BASE_ADDR.
  - in_ready=0, imem_we=0, imem_wdata=0, busy=0, done=0, err=0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: on start → LOAD; imem_addr←BASE_ADDR; err cleared.
  - LOAD: in_ready = !full. On an accepted beat with in_last=1 → DRAIN.
  - DRAIN: in_ready=0. When FIFO is empty and no write is pending → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - start while busy is ignored. in_valid outside LOAD is ignored (in_ready=0).
- Encoding (combinational, at push time); opcodes match the decoder's opcode set:
  - R: funct7|rs2|rs1|f3|rd|0110011.
  - I-ALU: imm[11:0]|rs1|f3|rd|0010011.
  - LOAD: imm[11:0]|rs1|010|rd|0000011 (funct3 forced to 010).
  - STORE: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011; imm[0] ignored.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - LUI: imm[31:12]|rd|0110111.
  - fmt 7: push NOP 0x00000013 and set err[0].
- Write port:
  - imem_we = busy && FIFO non-empty.
  - imem_wdata = FIFO head.
  - On imem_we && imem_ready: pop the entry, imem_addr += 1.
  - imem_addr wraps modulo 2^ADDR_W; the wrap sets err[1].
- Latency: a descriptor accepted at cycle N is presented on imem_* at cycle N+1 at the earliest.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle (no combinational ready path from imem_ready).
  - With imem_ready held low, the FIFO fills to DEPTH, then in_ready stays low until the first pop.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined:
  - in_imm is checked against the signed field range of its fmt: I/LOAD/STORE ±2^11, BRANCH ±2^12, JAL ±2^20.
  - BRANCH and JAL additionally require an even offset.
  - LUI requires imm[11:0]=0.
  - A violation pushes NOP 0x00000013 and sets err[1].
- Undefined: immediates are silently truncated as in the Encoding rules; err[1] reflects address wrap only.

Decomposition:
- Package rv_instr_pkg: opcode enum (LOAD, STORE, BRANCH, I_TYPE, R_TYPE, JAL, LUI), in_fmt enum, NOP_INSTR constant, FSM state typedef.
- The pipeline's main decoder imports the same opcode enum.
- One sub-module, sync_fifo (parameterised width/DEPTH, push/pop/full/empty, synchronous active-low reset).
- The encoder is a function in the package.

Test Plan:
- start; then R add rd=3 rs1=1 rs2=2 f3=0 f7=0 (last) → imem_addr 0 wdata 0x002081B3; done pulses; err=0.
- I addi rd=1 rs1=0 imm=5, LOAD rd=2 rs1=1 imm=8, STORE rs1=1 rs2=2 imm=4 (last) → 0x00500093, 0x0080A103, 0x0020A223 at addresses 0,1,2.
- BRANCH rs1=1 rs2=2 f3=0 imm=-4, JAL rd=1 imm=8, LUI rd=5 imm=0x12345000 → 0xFE208EE3, 0x008000EF, 0x123452B7.
- Hold imem_ready=0, push 6 beats → in_ready drops after 4 accepted. Release imem_ready → all 6 words written in order, addresses 0–5.
- fmt=7 → 0x00000013 written, err=01. With IMM_RANGE_CHECK_EN, I imm=4096 → NOP written, err[1]=1.
- Assert rst_n=0 mid-DRAIN with 3 entries queued → next cycle imem_we=0, busy=0, imem_addr=BASE_ADDR. A new start writes from address 0.

Source files
------------

// File: rtl/rv_instr_pkg.sv
// Shared RV32I definitions: opcodes, loader descriptor formats, loader FSM states and the field encoder.
// Build option IMM_RANGE_CHECK_EN turns on immediate range checking inside encode().
package rv_instr_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_I_TYPE = 7'b0010011,
    OP_R_TYPE = 7'b0110011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_LOAD   = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_BRANCH = 3'd4,
    FMT_JAL    = 3'd5,
    FMT_LUI    = 3'd6,
    FMT_RSVD   = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
    logic        range_err;
  } enc_t;

`ifdef IMM_RANGE_CHECK_EN
  // True when imm is representable as a signed value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] s;
    s = $unsigned($signed(imm) >>> (bits - 1));
    return (s == 32'h0) || (s == 32'hFFFF_FFFF);
  endfunction
`endif

  function automatic enc_t encode(input fmt_e fmt, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] imm);
    enc_t r;
    r.word      = NOP_INSTR;
    r.illegal   = 1'b0;
    r.range_err = 1'b0;
    case (fmt)
      FMT_R:      r.word = {f7, rs2, rs1, f3, rd, OP_R_TYPE};
      FMT_I:      r.word = {imm[11:0], rs1, f3, rd, OP_I_TYPE};
      FMT_LOAD:   r.word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      FMT_STORE:  r.word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      FMT_BRANCH: r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      FMT_JAL:    r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      FMT_LUI:    r.word = {imm[31:12], rd, OP_LUI};
      default:    r.illegal = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      FMT_I, FMT_LOAD, FMT_STORE: r.range_err = !fits_signed(imm, 12);
      FMT_BRANCH:                 r.range_err = !fits_signed(imm, 13) || imm[0];
      FMT_JAL:                    r.range_err = !fits_signed(imm, 21) || imm[0];
      FMT_LUI:                    r.range_err = (imm[11:0] != 12'h000);
      default:                    r.range_err = 1'b0;
    endcase
    if (r.range_err) r.word = NOP_INSTR;
`endif
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign full     = (count_reg == (PTR_W + 1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign pop_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Assembles RV32I words from field descriptors and streams them into instruction memory.
// Build option IMM_RANGE_CHECK_EN enables immediate range checks (violations load a NOP and set err[1]).
module instr_encode_loader
  import rv_instr_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        err_reg;
  logic              fifo_full, fifo_empty;
  logic [31:0]       fifo_head;
  logic              push, pop;
  enc_t              enc;

  assign enc  = encode(fmt_e'(in_fmt), in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
  assign push = in_valid && in_ready;
  assign pop  = imem_we && imem_ready;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (enc.word),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (push && in_last) state_next = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // in_ready depends only on registered FIFO state, never on imem_ready.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      S_LOAD:  begin in_ready = !fifo_full; busy = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign imem_we    = busy && !fifo_empty;
  assign imem_wdata = imem_we ? fifo_head : 32'h0;
  assign imem_addr  = addr_reg;
  assign err        = err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= ADDR_W'(BASE_ADDR);
      err_reg  <= 2'b00;
    end else if (state_reg == S_IDLE && start) begin
      addr_reg <= ADDR_W'(BASE_ADDR);
      err_reg  <= 2'b00;
    end else begin
      if (pop) begin
        addr_reg <= addr_reg + ADDR_W'(1);
        if (addr_reg == '1) err_reg[1] <= 1'b1;
      end
      if (push && enc.illegal)   err_reg[0] <= 1'b1;
      if (push && enc.range_err) err_reg[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: expected writes go to a scoreboard queue, a monitor checks each write.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, in_last;
  logic [2:0]  in_fmt, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        imem_we, imem_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done;
  logic [1:0]  err;

  always #5 clk = ~clk;

  instr_encode_loader #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_fmt     (in_fmt),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] next_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_write: observed addr 0x%h data 0x%h expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        $display("write addr=0x%h data=0x%h (expect 0x%h 0x%h)", imem_addr, imem_wdata, mon_e.addr, mon_e.data);
        chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
        chk("wr_data", imem_wdata, mon_e.data);
      end
    end
  end

  task automatic start_session();
    @(negedge clk);
    start     = 1'b1;
    next_addr = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input bit last, input logic [31:0] exp_word,
                      input bit expect_write);
    int cyc;
    @(negedge clk);
    in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $error("FAIL accept_timeout: observed in_ready 0 expected 1 within 200 cycles");
    end else begin
      $display("accept fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%h -> 0x%h", fmt, rd, rs1, rs2, imm, exp_word);
      if (expect_write) begin
        sb.push_back('{next_addr, exp_word});
        next_addr++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] imv;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; imem_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;

    // R-type add.
    start_session();
    chk("load_busy", 32'(busy), 32'd1);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3, 1'b1);
    wait_done("r_add");
    chk("r_add_err", 32'(err), 32'd0);

    // I / LOAD / STORE; funct3 is forced for LOAD and STORE.
    start_session();
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093, 1'b1);
    send(3'd2, 5'd2, 5'd1, 5'd0, 3'd7, 7'd0, 32'd8, 1'b0, 32'h0080A103, 1'b1);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd5, 7'd0, 32'd4, 1'b1, 32'h0020A223, 1'b1);
    wait_done("i_ld_st");

    // BRANCH / JAL / LUI.
    start_session();
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3, 1'b1);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 32'h008000EF, 1'b1);
    send(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7, 1'b1);
    wait_done("br_jal_lui");

    // Back-pressure: FIFO fills to 4, then in_ready holds low.
    imem_ready = 1'b0;
    start_session();
    for (int i = 0; i < 4; i++) begin
      imv = 32'(i * 37);
      send(3'd1, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, imv, 1'b0, enc_i(5'(i + 1), 5'd2, 3'd0, imv[11:0]), 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_imem_we", 32'(imem_we), 32'd1);
      @(negedge clk);
    end
    chk("full_addr_held", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #1;
    imem_ready = 1'b1;
    for (int i = 4; i < 6; i++) begin
      imv = (i == 5) ? 32'hFFFF_FFFF : 32'(i * 37);
      send(3'd1, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, imv, (i == 5), enc_i(5'(i + 1), 5'd2, 3'd0, imv[11:0]), 1'b1);
    end
    wait_done("backpressure");
    chk("backpressure_addr", 32'(imem_addr), 32'd6);

    // Reserved format loads a NOP and flags err[0].
    start_session();
    send(3'd7, 5'd9, 5'd9, 5'd9, 3'd1, 7'd1, 32'd77, 1'b1, 32'h00000013, 1'b1);
    wait_done("fmt7");
    chk("fmt7_err", 32'(err), 32'd1);

    // Out-of-range I immediate.
    start_session();
`ifdef IMM_RANGE_CHECK_EN
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b1, 32'h00000013, 1'b1);
    wait_done("imm_range");
    chk("imm_range_err", 32'(err), 32'd2);
`else
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b1, 32'h00000093, 1'b1);
    wait_done("imm_trunc");
    chk("imm_trunc_err", 32'(err), 32'd0);
`endif

    // Reset mid-DRAIN with 3 entries queued.
    imem_ready = 1'b0;
    start_session();
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0, 1'b0);
    send(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0, 1'b0);
    send(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_imem_we", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_imem_we", 32'(imem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("postrst_imem_we", 32'(imem_we), 32'd0);
    start_session();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3, 1'b1);
    wait_done("after_rst");
    chk("after_rst_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
